regfile_mp: RTL and testbench

Parametrised multi-port integer register file; the next-generation replacement for the single-write/dual-read core register file. It is sized by data width, entry count, read-port count and write-port count, and keeps an optional hardwired zero register. Storage is cleared by a one-entry-per-cycle sweep FSM after reset or on request, so the array needs no asynchronous reset. It sits between decode (read ports) and writeback (write ports) in the 3-stage core and in wider-issue variants.

---
 rtl/regfile_mp.sv | 199 +++++++++++++++++++
 tb/tb_regfile_mp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port integer register file
//
// Purpose:
//   NRD combinational read ports and NWR synchronous write ports over NREGS
//   entries of XLEN bits. An optional hardwired zero register (ZERO_REG=1)
//   makes entry 0 read as 0 and ignore writes.
//
//   The storage array has no reset of its own. After reset, or when clr_req
//   is seen, a sweep FSM clears one entry per clock. While the sweep runs,
//   ready=0, writes are dropped and every read port returns 0.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN  -- when defined, a read whose address matches an
//                         enabled write port returns that cycle's wr_data.
//                         The highest-index matching port wins. This adds a
//                         combinational wr_* -> rd_data path. When the macro
//                         is undefined, reads return stored values only.
//
// Ports:
//   clk      in   1         single clock, rising edge
//   reset_n  in   1         asynchronous active-low reset (FSM only)
//   clr_req  in   1         request a full clear sweep
//   rd_addr  in   NRD*AW    read address, port p at [p*AW +: AW]
//   rd_data  out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//   wr_en    in   NWR       per-port write enable
//   wr_addr  in   NWR*AW    write address, port q at [q*AW +: AW]
//   wr_data  in   NWR*XLEN  write data, port q at [q*XLEN +: XLEN]
//   ready    out  1         1 = RUN: writes accepted, reads valid
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    parameter int  NRD      = 2,
    parameter int  NWR      = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr_req,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    // When NREGS is a power of two, every address is in range and the range
    // check folds away.
    localparam bit ALL_ADDR_VALID = (NREGS == (1 << AW));

    genvar gi;

    // -------------------------------------------------------------------------
    // Address qualification helpers
    // -------------------------------------------------------------------------
    function automatic logic f_in_range(input logic [AW-1:0] addr);
        return ALL_ADDR_VALID || (int'(addr) < NREGS);
    endfunction

    function automatic logic f_is_hard_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // -------------------------------------------------------------------------
    // Sweep / run FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                // A new request restarts the sweep from entry 0. The entry
                // at the current count is still cleared on this edge.
                if (clr_req) begin
                    w_cnt_next = '0;
                end else if (r_cnt == LAST_IDX) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + AW'(1);
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign ready = (r_state == ST_RUN);

    // -------------------------------------------------------------------------
    // Storage: one register per entry, each with its own write-port decode
    // -------------------------------------------------------------------------
    logic [NREGS-1:0][XLEN-1:0] w_ent_q;

    for (gi = 0; gi < NREGS; gi++) begin : g_ent
        localparam logic [AW-1:0] IDX       = AW'(gi);
        localparam bit            HARD_ZERO = (ZERO_REG != 0) && (gi == 0);

        logic            w_hit;
        logic [XLEN-1:0] w_val;
        logic            w_clr;
        logic            w_we;
        logic [XLEN-1:0] r_q;

        // Ascending scan, so a higher-index port that targets this entry
        // overrides a lower one.
        always_comb begin
            w_hit = 1'b0;
            w_val = '0;
            for (int q = 0; q < NWR; q++) begin
                if (wr_en[q] && (wr_addr[q*AW +: AW] == IDX)) begin
                    w_hit = 1'b1;
                    w_val = wr_data[q*XLEN +: XLEN];
                end
            end
        end

        assign w_clr = (r_state == ST_CLEAR) && (r_cnt == IDX);
        assign w_we  = ready && w_hit && !HARD_ZERO;

        // The sweep and user writes never coincide: user writes need
        // ready=1, and the sweep runs only while ready=0.
        always_ff @(posedge clk) begin
            if (w_clr) begin
                r_q <= '0;
            end else if (w_we) begin
                r_q <= w_val;
            end
        end

        assign w_ent_q[gi] = r_q;
    end

    // -------------------------------------------------------------------------
    // Read ports (combinational)
    // -------------------------------------------------------------------------
    for (gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_valid;
        logic [XLEN-1:0] w_data;

        assign w_addr  = rd_addr[gi*AW +: AW];
        // ready=0 masks storage whose contents are undefined during a sweep.
        assign w_valid = ready && f_in_range(w_addr) && !f_is_hard_zero(w_addr);

        always_comb begin
            w_data = '0;
            if (w_valid) begin
                w_data = w_ent_q[w_addr];
`ifdef REGFILE_BYPASS_EN
                // Forward this cycle's write. The ascending scan gives
                // priority to the highest-index matching port, as the
                // write path does.
                for (int q = 0; q < NWR; q++) begin
                    if (wr_en[q] && (wr_addr[q*AW +: AW] == w_addr)) begin
                        w_data = wr_data[q*XLEN +: XLEN];
                    end
                end
`endif
            end
        end

        assign rd_data[gi*XLEN +: XLEN] = w_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- directed self-checking bench for regfile_mp
//
// Two instances share every input. u_dut has ZERO_REG=1 and u_dut_nz has
// ZERO_REG=0. Both use NRD=2 and NWR=2. Expected read data is pushed to a
// scoreboard queue when stimulus is driven. It is popped and compared once
// the combinational read has settled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk     = 1'b0;
    logic                reset_n = 1'b0;
    logic                clr_req = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NWR-1:0]      wr_en   = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*XLEN-1:0] wr_data = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD*XLEN-1:0] rd_data_nz;
    logic                ready;
    logic                ready_nz;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .clr_req(clr_req),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0)
    ) u_dut_nz (
        .clk(clk), .reset_n(reset_n), .clr_req(clr_req),
        .rd_addr(rd_addr), .rd_data(rd_data_nz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_nz)
    );

    typedef struct {
        string           tag;
        bit              nz;
        int              port;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        if (obs === exp) $display("ok   %s: 0x%08h", tag, obs);
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, "_ready"},    XLEN'(ready),    XLEN'(exp));
        chk({tag, "_ready_nz"}, XLEN'(ready_nz), XLEN'(exp));
    endtask

    function automatic void expect_rd(input string tag, input bit nz,
                                      input int port, input logic [XLEN-1:0] exp);
        exp_t e;
        e.tag  = tag;
        e.nz   = nz;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    task automatic drain();
        exp_t            e;
        logic [XLEN-1:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.nz ? rd_data_nz[e.port*XLEN +: XLEN] : rd_data[e.port*XLEN +: XLEN];
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic set_wr(input int port, input logic en, input int addr,
                          input logic [XLEN-1:0] data);
        wr_en[port]                = en;
        wr_addr[port*AW +: AW]     = AW'(addr);
        wr_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic wr_idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    // ready must stay 0 for NREGS-1 edges and rise on edge NREGS.
    task automatic sweep_and_check(input string tag);
        for (int i = 1; i < NREGS; i++) begin
            tick();
            chk_ready($sformatf("%s_e%0d", tag, i), 1'b0);
        end
        tick();
        chk_ready($sformatf("%s_e%0d", tag, NREGS), 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        #1;
        chk_ready("reset", 1'b0);
        expect_rd("reset_rd0", 1'b0, 0, 32'h0);
        expect_rd("reset_rd1", 1'b0, 1, 32'h0);
        expect_rd("reset_nz_rd0", 1'b1, 0, 32'h0);
        drain();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sweep_and_check("init");

        // ---------------- every entry cleared ----------------
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a);
            set_rd(1, NREGS - 1 - a);
            expect_rd($sformatf("init_x%0d", a), 1'b0, 0, 32'h0);
            expect_rd($sformatf("init_nz_x%0d", NREGS - 1 - a), 1'b1, 1, 32'h0);
            #2;
            drain();
        end

        // ---------------- same-address collision ----------------
        tick();
        set_rd(0, 5);
        set_wr(0, 1'b1, 5, 32'h1111_1111);
        set_wr(1, 1'b1, 5, 32'h2222_2222);
        #1;
        expect_rd("coll_same", 1'b0, 0, BYP ? 32'h2222_2222 : 32'h0);
        drain();
        tick();
        wr_idle();
        #1;
        expect_rd("coll_next", 1'b0, 0, 32'h2222_2222);
        drain();

        // A disabled higher port must not override an enabled lower one.
        set_wr(0, 1'b1, 9, 32'hAAAA_0009);
        set_wr(1, 1'b0, 9, 32'hBBBB_0009);
        tick();
        wr_idle();
        set_rd(1, 9);
        #1;
        expect_rd("dis_port_x9", 1'b0, 1, 32'hAAAA_0009);
        drain();

        // ---------------- x0 handling ----------------
        set_rd(0, 0);
        set_rd(1, 0);
        set_wr(0, 1'b1, 0, 32'hDEAD_BEEF);
        #1;
        expect_rd("x0_zr_same", 1'b0, 0, 32'h0);
        expect_rd("x0_nz_same", 1'b1, 0, BYP ? 32'hDEAD_BEEF : 32'h0);
        drain();
        tick();
        wr_idle();
        #1;
        expect_rd("x0_zr_next_p0", 1'b0, 0, 32'h0);
        expect_rd("x0_zr_next_p1", 1'b0, 1, 32'h0);
        expect_rd("x0_nz_next_p0", 1'b1, 0, 32'hDEAD_BEEF);
        expect_rd("x0_nz_next_p1", 1'b1, 1, 32'hDEAD_BEEF);
        drain();

        // ---------------- write then read in the same cycle ----------------
        set_wr(0, 1'b1, 7, 32'h0000_0777);
        tick();
        set_rd(0, 7);
        set_rd(1, 7);
        set_wr(0, 1'b1, 7, 32'hCAFE_F00D);
        #1;
        expect_rd("x7_same_p0", 1'b0, 0, BYP ? 32'hCAFE_F00D : 32'h0000_0777);
        expect_rd("x7_same_p1", 1'b0, 1, BYP ? 32'hCAFE_F00D : 32'h0000_0777);
        drain();
        tick();
        wr_idle();
        #1;
        expect_rd("x7_next_p0", 1'b0, 0, 32'hCAFE_F00D);
        expect_rd("x7_next_p1", 1'b0, 1, 32'hCAFE_F00D);
        drain();

        // ---------------- clr_req from RUN ----------------
        set_rd(0, 3);
        set_rd(1, 5);
        set_wr(0, 1'b1, 3, 32'h0000_1234);
        clr_req = 1'b1;
        #1;
        expect_rd("clr_same_x3", 1'b0, 0, BYP ? 32'h0000_1234 : 32'h0);
        expect_rd("clr_same_x5", 1'b0, 1, 32'h2222_2222);
        drain();
        tick();
        clr_req = 1'b0;
        wr_idle();
        chk_ready("clr_edge", 1'b0);
        expect_rd("clr_edge_x3", 1'b0, 0, 32'h0);
        expect_rd("clr_edge_x5", 1'b0, 1, 32'h0);
        drain();
        for (int i = 1; i < NREGS; i++) begin
            if (i == 5) begin
                // Entry 0 has already been swept; this write must be dropped.
                set_rd(0, 0);
                set_wr(0, 1'b1, 0, 32'hBAD0_BAD0);
                #1;
                expect_rd("clear_wr_same", 1'b1, 0, 32'h0);
                drain();
            end
            tick();
            wr_idle();
            chk_ready($sformatf("clr_e%0d", i), 1'b0);
        end
        tick();
        chk_ready($sformatf("clr_e%0d", NREGS), 1'b1);
        set_rd(0, 3);
        set_rd(1, 0);
        #1;
        expect_rd("post_clr_x3", 1'b0, 0, 32'h0);
        expect_rd("post_clr_nz_x0", 1'b1, 1, 32'h0);
        expect_rd("post_clr_nz_x3", 1'b1, 0, 32'h0);
        drain();

        // ---------------- async reset mid-RUN ----------------
        tick();
        set_rd(0, 12);
        set_wr(0, 1'b1, 12, 32'h1212_1212);
        tick();
        wr_idle();
        #1;
        expect_rd("x12_run", 1'b0, 0, 32'h1212_1212);
        drain();
        #2;
        reset_n = 1'b0;
        #1;
        chk_ready("run_rst", 1'b0);
        expect_rd("run_rst_x12", 1'b0, 0, 32'h0);
        drain();
        reset_n = 1'b1;

        // ---------------- async reset mid-sweep (cnt=10) ----------------
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_ready($sformatf("pre_e%0d", i), 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk_ready("sweep_rst", 1'b0);
        reset_n = 1'b1;
        sweep_and_check("resweep");
        #1;
        expect_rd("resweep_x12", 1'b0, 0, 32'h0);
        expect_rd("resweep_nz_x12", 1'b1, 0, 32'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
